// File: rtl/usb_reg_responder.sv
// Target-side responder for the host USB parallel register bus: registers the pins, turns each
// nCS fall into one reg_write/reg_read pulse and drives read data back onto the bus.
module usb_reg_responder #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                                 usb_clk,
  input  logic                                 resetn,
  input  logic [pADDR_WIDTH-1:0]               usb_addr,
  input  logic [7:0]                           usb_din,
  output logic [7:0]                           usb_dout,
  output logic                                 usb_isout,
  input  logic                                 usb_nrd,
  input  logic                                 usb_nwe,
  input  logic                                 usb_ncs,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           reg_datao,
  input  logic [7:0]                           reg_datai,
  output logic                                 reg_addrvalid,
  output logic                                 reg_write,
  output logic                                 reg_read,
  output logic                                 proto_err
);

  // state    | meaning
  // IDLE     | waiting for a fresh nCS fall
  // WR       | reg_write pulse to the register blocks
  // RD_REQ   | reg_read pulse, read data captured on exit
  // RD_DRIVE | usb_dout driven while nRD stays low
  // WAIT_REL | waiting for nCS to return high
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_REQ   = 3'd2,
    RD_DRIVE = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  state_t                                 state_q;
  logic [pADDR_WIDTH-1:0]                 addr_s1_q;
  logic [7:0]                             din_s1_q;
  logic                                   nrd_s1_q;
  logic                                   nwe_s1_q;
  logic                                   ncs_s1_q;
  logic                                   ncs_prev_q;
  logic                                   rst_done_q;
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address_q;
  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt_q;
  logic [7:0]                             reg_datao_q;
  logic [7:0]                             dout_q;
  logic                                   isout_q;
  logic                                   reg_write_q;
  logic                                   reg_read_q;
  logic                                   proto_err_q;
  logic                                   strobe;

  assign strobe = ~ncs_s1_q & ncs_prev_q;

  always_ff @(posedge usb_clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_s1_q     <= '0;
      din_s1_q      <= '0;
      nrd_s1_q      <= 1'b1;
      nwe_s1_q      <= 1'b1;
      ncs_s1_q      <= 1'b1;
      ncs_prev_q    <= 1'b0;
      rst_done_q    <= 1'b0;
      reg_address_q <= '0;
      reg_bytecnt_q <= '0;
      reg_datao_q   <= '0;
      dout_q        <= '0;
      isout_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_read_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      addr_s1_q  <= usb_addr;
      din_s1_q   <= usb_din;
      nrd_s1_q   <= usb_nrd;
      nwe_s1_q   <= usb_nwe;
      ncs_s1_q   <= usb_ncs;
      rst_done_q <= 1'b1;
      // The reset value of ncs_s1 is not a real observation of the pin, so it must not
      // count as the "high" half of a fall on the first edge after reset.
      ncs_prev_q  <= rst_done_q ? ncs_s1_q : 1'b0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strobe) begin
            reg_address_q <= addr_s1_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
            reg_bytecnt_q <= addr_s1_q[pBYTECNT_SIZE-1:0];
            reg_datao_q   <= din_s1_q;
            if (!nwe_s1_q && nrd_s1_q) begin
              state_q     <= WR;
              reg_write_q <= 1'b1;
            end else if (!nrd_s1_q && nwe_s1_q) begin
              state_q    <= RD_REQ;
              reg_read_q <= 1'b1;
            end else begin
              if (!nrd_s1_q && !nwe_s1_q) proto_err_q <= 1'b1;
              state_q <= WAIT_REL;
            end
          end
        end
        WR: state_q <= WAIT_REL;
        RD_REQ: begin
          dout_q  <= reg_datai;
          isout_q <= 1'b1;
          state_q <= RD_DRIVE;
        end
        RD_DRIVE: begin
          if (nrd_s1_q) begin
            isout_q <= 1'b0;
            state_q <= WAIT_REL;
          end
        end
        WAIT_REL: if (ncs_s1_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A host write strobe always wins the pad: never drive while nWE is seen low.
  assign usb_isout     = isout_q & nwe_s1_q;
  assign usb_dout      = dout_q;
  assign reg_address   = reg_address_q;
  assign reg_bytecnt   = reg_bytecnt_q;
  assign reg_datao     = reg_datao_q;
  assign reg_addrvalid = ~ncs_s1_q;
  assign reg_write     = reg_write_q;
  assign reg_read      = reg_read_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_usb_reg_responder.sv
// Scoreboard bench for usb_reg_responder: bus transactions push expectations, a negedge
// monitor pops them on every reg_write/reg_read pulse.
module tb_usb_reg_responder;

  typedef struct {
    logic [20:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic        usb_clk = 1'b0;
  logic        resetn;
  logic [20:0] usb_addr;
  logic [7:0]  usb_din;
  logic [7:0]  usb_dout;
  logic        usb_isout;
  logic        usb_nrd;
  logic        usb_nwe;
  logic        usb_ncs;
  logic [13:0] reg_address;
  logic [6:0]  reg_bytecnt;
  logic [7:0]  reg_datao;
  logic [7:0]  reg_datai;
  logic        reg_addrvalid;
  logic        reg_write;
  logic        reg_read;
  logic        proto_err;

  txn_t wr_q[$];
  txn_t rd_q[$];
  txn_t mon_t;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;

  usb_reg_responder #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) dut (
    .usb_clk       (usb_clk),
    .resetn        (resetn),
    .usb_addr      (usb_addr),
    .usb_din       (usb_din),
    .usb_dout      (usb_dout),
    .usb_isout     (usb_isout),
    .usb_nrd       (usb_nrd),
    .usb_nwe       (usb_nwe),
    .usb_ncs       (usb_ncs),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .reg_datao     (reg_datao),
    .reg_datai     (reg_datai),
    .reg_addrvalid (reg_addrvalid),
    .reg_write     (reg_write),
    .reg_read      (reg_read),
    .proto_err     (proto_err)
  );

  always #5 usb_clk = ~usb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge usb_clk) begin
    if (reg_write === 1'b1) begin
      wr_cnt++;
      if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        mon_t = wr_q.pop_front();
        chk("wr_addr", {18'd0, reg_address}, {18'd0, mon_t.addr[20:7]});
        chk("wr_bytecnt", {25'd0, reg_bytecnt}, {25'd0, mon_t.addr[6:0]});
        chk("wr_data", {24'd0, reg_datao}, {24'd0, mon_t.data});
      end
    end
    if (reg_read === 1'b1) begin
      rd_cnt++;
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        mon_t = rd_q.pop_front();
        chk("rd_addr", {18'd0, reg_address}, {18'd0, mon_t.addr[20:7]});
        chk("rd_bytecnt", {25'd0, reg_bytecnt}, {25'd0, mon_t.addr[6:0]});
      end
    end
  end

  task automatic do_write(input logic [20:0] addr, input logic [7:0] data, input int hold);
    txn_t t;
    t.addr = addr;
    t.data = data;
    wr_q.push_back(t);
    @(posedge usb_clk); #2;
    usb_addr = addr; usb_din = data; usb_nwe = 1'b0; usb_ncs = 1'b0;
    @(posedge usb_clk); #1;
    chk("wr_addrvalid", {31'd0, reg_addrvalid}, 32'd1);
    repeat (hold - 1) @(posedge usb_clk);
    #2;
    usb_nwe = 1'b1; usb_ncs = 1'b1;
    repeat (2) @(posedge usb_clk);
  endtask

  // Waits (bounded) for the pad enable after a read strobe; returns edges elapsed.
  task automatic start_read(input logic [20:0] addr, input logic [7:0] data, output int lat);
    txn_t t;
    t.addr = addr;
    t.data = data;
    rd_q.push_back(t);
    @(posedge usb_clk); #2;
    reg_datai = data; usb_addr = addr; usb_nrd = 1'b0; usb_ncs = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge usb_clk); #1;
      lat = i;
      if (usb_isout === 1'b1) break;
    end
  endtask

  task automatic do_read(input logic [20:0] addr, input logic [7:0] data, input bit contend);
    int lat;
    start_read(addr, data, lat);
    chk("rd_latency", lat, 32'd3);
    chk("rd_dout", {24'd0, usb_dout}, {24'd0, data});
    repeat (3) begin
      @(posedge usb_clk); #1;
      chk("rd_hold_isout", {31'd0, usb_isout}, 32'd1);
      chk("rd_hold_dout", {24'd0, usb_dout}, {24'd0, data});
    end
    if (contend) begin
      #1 usb_nwe = 1'b0;
      @(posedge usb_clk); #1;
      chk("contention_off", {31'd0, usb_isout}, 32'd0);
      #1 usb_nwe = 1'b1;
      @(posedge usb_clk); #1;
      chk("contention_back", {31'd0, usb_isout}, 32'd1);
    end
    #1 usb_nrd = 1'b1; usb_ncs = 1'b1;
    @(posedge usb_clk); #1;
    chk("rd_isout_pre_drop", {31'd0, usb_isout}, 32'd1);
    @(posedge usb_clk); #1;
    chk("rd_isout_drop", {31'd0, usb_isout}, 32'd0);
    repeat (2) @(posedge usb_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, r0, lat;
    resetn = 1'b0; usb_addr = '0; usb_din = '0; reg_datai = '0;
    usb_nrd = 1'b1; usb_nwe = 1'b1; usb_ncs = 1'b1;
    repeat (3) @(posedge usb_clk);
    #1;
    chk("rst_dout", {24'd0, usb_dout}, 32'd0);
    chk("rst_isout", {31'd0, usb_isout}, 32'd0);
    chk("rst_write", {31'd0, reg_write}, 32'd0);
    chk("rst_read", {31'd0, reg_read}, 32'd0);
    chk("rst_proto", {31'd0, proto_err}, 32'd0);
    chk("rst_addrvalid", {31'd0, reg_addrvalid}, 32'd0);
    #1 resetn = 1'b1;
    repeat (2) @(posedge usb_clk);

    // single write, then a read
    w0 = wr_cnt;
    do_write(21'h000B02, 8'hA5, 2);
    chk("t1_one_write", wr_cnt - w0, 32'd1);
    r0 = rd_cnt;
    do_read(21'h000B83, 8'h3C, 1'b0);
    chk("t2_one_read", rd_cnt - r0, 32'd1);

    // nCS held low for 10 cycles: still one pulse
    w0 = wr_cnt;
    do_write(21'h001A7F, 8'h5A, 10);
    chk("t3_one_write", wr_cnt - w0, 32'd1);

    // read with a write-strobe contention blip
    do_read(21'h1FFF81, 8'hC3, 1'b1);

    // protocol error: nRD and nWE both low
    w0 = wr_cnt; r0 = rd_cnt;
    @(posedge usb_clk); #2;
    usb_addr = 21'h000B00; usb_nrd = 1'b0; usb_nwe = 1'b0; usb_ncs = 1'b0;
    repeat (4) @(posedge usb_clk);
    #2 usb_nrd = 1'b1; usb_nwe = 1'b1; usb_ncs = 1'b1;
    repeat (3) @(posedge usb_clk);
    #1;
    chk("t4_no_write", wr_cnt - w0, 32'd0);
    chk("t4_no_read", rd_cnt - r0, 32'd0);
    chk("t4_proto_set", {31'd0, proto_err}, 32'd1);
    do_write(21'h000C01, 8'h77, 2);
    do_read(21'h000C02, 8'h99, 1'b0);
    chk("t4_proto_sticky", {31'd0, proto_err}, 32'd1);

    // reset while driving read data
    start_read(21'h000D05, 8'hE1, lat);
    chk("t5_isout_before", {31'd0, usb_isout}, 32'd1);
    #1 resetn = 1'b0;
    @(posedge usb_clk); #1;
    chk("t5_isout_rst", {31'd0, usb_isout}, 32'd0);
    chk("t5_read_rst", {31'd0, reg_read}, 32'd0);
    chk("t5_proto_rst", {31'd0, proto_err}, 32'd0);
    w0 = wr_cnt; r0 = rd_cnt;
    #1 resetn = 1'b1;
    repeat (6) @(posedge usb_clk);
    #1;
    chk("t5_no_strobe_rd", rd_cnt - r0, 32'd0);
    chk("t5_no_strobe_wr", wr_cnt - w0, 32'd0);
    chk("t5_addrvalid", {31'd0, reg_addrvalid}, 32'd1);
    chk("t5_isout_after", {31'd0, usb_isout}, 32'd0);
    #1 usb_nrd = 1'b1; usb_ncs = 1'b1;
    repeat (3) @(posedge usb_clk);

    // back-to-back 4-byte write
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++)
      do_write(21'h000B00 + 21'(i), 8'h11 * 8'(i + 1), 1);
    chk("t6_four_writes", wr_cnt - w0, 32'd4);

    repeat (4) @(posedge usb_clk);
    chk("wr_queue_empty", wr_q.size(), 32'd0);
    chk("rd_queue_empty", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
